// File: rtl/counter_input_cond_if.sv
// Board-side input/output bundle for the counter input conditioner.
// The slave side is the conditioner; the master side drives the raw inputs.
interface counter_input_cond_if;
    logic switch_raw;
    logic btn_raw;
    logic auto_en;
    logic dir;
    logic step;
    logic dir_changed;

    modport master (
        output switch_raw,
        output btn_raw,
        output auto_en,
        input  dir,
        input  step,
        input  dir_changed
    );

    modport slave (
        input  switch_raw,
        input  btn_raw,
        input  auto_en,
        output dir,
        output step,
        output dir_changed
    );
endinterface

// File: rtl/counter_input_cond.sv
// Input conditioning for an up/down counter: synchronizes and debounces the
// direction switch and step button, and merges manual and periodic steps.

module counter_input_cond_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic flip
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             flip_s;

    // Stable level changes once the synced input has differed for the full window.
    always_comb begin
        flip_s = 1'b0;
        if ((sync_r != stable_r) && (cnt_r == CNT_MAX)) begin
            flip_s = 1'b1;
        end else begin
            flip_s = 1'b0;
        end
    end

    // Two-flop synchronizer followed by the stable-level counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r   <= 1'b0;
            sync_r   <= 1'b0;
            stable_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
            if (sync_r == stable_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (flip_s) begin
                stable_r <= sync_r;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign stable = stable_r;
    assign flip   = flip_s;
endmodule

module counter_input_cond #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_CYCLES     = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_input_cond_if.slave    bus
);
    localparam int PRE_W = $clog2(TICK_CYCLES);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_CYCLES - 1);

    logic             dir_s;
    logic             sw_flip_s;
    logic             btn_stable_s;
    logic             btn_flip_s;
    logic             btn_event_s;
    logic             tick_event_s;
    logic             event_s;
    logic [PRE_W-1:0] presc_r;
    logic             step_r;
    logic             dir_changed_r;
    logic             pending_r;

    counter_input_cond_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.switch_raw),
        .stable(dir_s),
        .flip  (sw_flip_s)
    );

    counter_input_cond_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_raw),
        .stable(btn_stable_s),
        .flip  (btn_flip_s)
    );

    // Step events: debounced button rising this edge, or prescaler wrapping.
    always_comb begin
        btn_event_s  = btn_flip_s & ~btn_stable_s;
        tick_event_s = 1'b0;
        if (bus.auto_en && (presc_r == PRE_MAX)) begin
            tick_event_s = 1'b1;
        end else begin
            tick_event_s = 1'b0;
        end
        event_s = btn_event_s | tick_event_s;
    end

    // Auto-step prescaler; a direction change restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (sw_flip_s || !bus.auto_en || tick_event_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    // A step coinciding with a direction change is deferred one cycle so the
    // downstream counter never sees step and dir_changed together.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r        <= 1'b0;
            dir_changed_r <= 1'b0;
            pending_r     <= 1'b0;
        end else if (sw_flip_s) begin
            step_r        <= 1'b0;
            dir_changed_r <= 1'b1;
            pending_r     <= pending_r | event_s;
        end else begin
            step_r        <= pending_r | event_s;
            dir_changed_r <= 1'b0;
            pending_r     <= 1'b0;
        end
    end

    assign bus.dir         = dir_s;
    assign bus.step        = step_r;
    assign bus.dir_changed = dir_changed_r;
endmodule

// File: tb/tb_counter_input_cond.sv
// Directed and randomized checks of counter_input_cond against a cycle-level
// behavioural reference (DEBOUNCE_CYCLES=4, TICK_CYCLES=5).
module tb_counter_input_cond;
    localparam int DB = 4;
    localparam int TK = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    counter_input_cond_if bus ();

    counter_input_cond #(
        .DEBOUNCE_CYCLES(DB),
        .TICK_CYCLES    (TK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference state: raw samples waiting in the synchronizer, run lengths of
    // disagreement, debounced levels, enabled cycles since the last period start.
    bit sw_pipe[2];
    bit btn_pipe[2];
    int run_sw, run_btn, en_cnt;
    bit m_dir, m_btn, m_pend, e_step, e_dc;

    task automatic chk(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(bit sw, bit btn, bit en, bit r);
        bit flip, rise, tick, ev;
        if (r) begin
            sw_pipe = '{1'b0, 1'b0}; btn_pipe = '{1'b0, 1'b0};
            run_sw = 0; run_btn = 0; en_cnt = 0;
            m_dir = 1'b0; m_btn = 1'b0; m_pend = 1'b0; e_step = 1'b0; e_dc = 1'b0;
            return;
        end
        flip = 1'b0; rise = 1'b0; tick = 1'b0;
        if (sw_pipe[1] != m_dir) begin
            run_sw++;
            if (run_sw == DB) begin m_dir = ~m_dir; flip = 1'b1; run_sw = 0; end
        end else run_sw = 0;
        if (btn_pipe[1] != m_btn) begin
            run_btn++;
            if (run_btn == DB) begin m_btn = ~m_btn; rise = m_btn; run_btn = 0; end
        end else run_btn = 0;
        sw_pipe[1] = sw_pipe[0];  sw_pipe[0] = sw;
        btn_pipe[1] = btn_pipe[0]; btn_pipe[0] = btn;
        if (en) begin
            en_cnt++;
            if (en_cnt == TK) begin tick = 1'b1; en_cnt = 0; end
        end else en_cnt = 0;
        if (flip) en_cnt = 0;
        ev = rise | tick;
        if (flip) begin
            e_dc = 1'b1; e_step = 1'b0; m_pend = m_pend | ev;
        end else begin
            e_dc = 1'b0; e_step = ev | m_pend; m_pend = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(bus.switch_raw, bus.btn_raw, bus.auto_en, rst);
        #1;
        chk("dir", bus.dir, m_dir);
        chk("step", bus.step, e_step);
        chk("dir_changed", bus.dir_changed, e_dc);
        chk("step_dc_exclusive", bus.step & bus.dir_changed, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.switch_raw = 1'b0; bus.btn_raw = 1'b0; bus.auto_en = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int steps, sw_hold, btn_hold;
        bus.switch_raw = 1'b0; bus.btn_raw = 1'b0; bus.auto_en = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        chk("reset_dir", bus.dir, 1'b0);
        chk("reset_step", bus.step, 1'b0);
        chk("reset_dc", bus.dir_changed, 1'b0);
        rst = 1'b0;

        // Switch sampled high at edge 10 -> dir after edge 15.
        for (int k = 0; k < 10; k++) cyc();
        bus.switch_raw = 1'b1;
        for (int k = 10; k < 18; k++) begin
            cyc();
            chk("sw_rise_dir", bus.dir, (k >= 15));
            chk("sw_rise_dc", bus.dir_changed, (k == 15));
            chk("sw_rise_step", bus.step, 1'b0);
        end

        // Short bounce must not change dir.
        do_reset();
        bus.switch_raw = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        bus.switch_raw = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("bounce_dir", bus.dir, 1'b0);
            chk("bounce_dc", bus.dir_changed, 1'b0);
        end

        // Auto-step period: steps after edges 4, 9, 14.
        do_reset();
        bus.auto_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            chk("auto_step", bus.step, (k == 4 || k == 9 || k == 14));
        end

        // Held button gives one step; release gives none.
        do_reset();
        bus.btn_raw = 1'b1;
        steps = 0;
        for (int k = 0; k < 10; k++) begin cyc(); steps += int'(bus.step); end
        chk("btn_press_one_step", (steps == 1), 1'b1);
        bus.btn_raw = 1'b0;
        steps = 0;
        for (int k = 0; k < 10; k++) begin cyc(); steps += int'(bus.step); end
        chk("btn_release_no_step", (steps == 0), 1'b1);

        // Tick and dir toggle on the same edge (edge 9).
        do_reset();
        bus.auto_en = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        bus.switch_raw = 1'b1;
        for (int k = 4; k < 16; k++) begin
            cyc();
            chk("align_dc", bus.dir_changed, (k == 9));
            chk("align_step", bus.step, (k == 4 || k == 10 || k == 14));
        end

        // Reset mid-debounce with auto-step running.
        do_reset();
        bus.auto_en = 1'b1;
        bus.switch_raw = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        rst = 1'b1;
        cyc();
        chk("midrst_dir", bus.dir, 1'b0);
        chk("midrst_step", bus.step, 1'b0);
        chk("midrst_dc", bus.dir_changed, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("midrst_redebounce_dir", bus.dir, (k >= 5));
            if (k == 0) chk("midrst_first_step", bus.step, 1'b0);
        end

        // Randomized phase against the reference.
        do_reset();
        sw_hold = 0; btn_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (sw_hold == 0) begin
                bus.switch_raw = ~bus.switch_raw;
                sw_hold = int'($urandom_range(1, 9));
            end else sw_hold--;
            if (btn_hold == 0) begin
                bus.btn_raw = ~bus.btn_raw;
                btn_hold = int'($urandom_range(1, 9));
            end else btn_hold--;
            if ($urandom_range(0, 24) == 0) bus.auto_en = ~bus.auto_en;
            rst = ($urandom_range(0, 299) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
